// File: rtl/seq_detector_mealy_param.sv
// Parametrised Mealy serial-pattern detector with runtime pattern load, overlap mode and saturating match counter.
// Optional: define SEQ_DET_MASK_EN to add a per-bit don't-care mask (pattern_mask_in / mask_q).
module seq_detector_mealy_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap_en,
    input  logic             pattern_ld,
    input  logic [PAT_W-1:0] pattern_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pattern_mask_in,
`endif
    input  logic             count_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-2:0]  hist_q;
    logic [FILL_W-1:0] fill_q;
    logic [PAT_W-1:0]  window;
    logic              pat_eq;
    logic              hit;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  mask_q;
`endif

    // Candidate word: stored history plus the bit arriving this cycle.
    always_comb begin
        window = {hist_q, in};
`ifdef SEQ_DET_MASK_EN
        pat_eq = (((window ^ pat_q) & mask_q) == {PAT_W{1'b0}});
`else
        pat_eq = (window == pat_q);
`endif
        hit = in_valid & ~pattern_ld & ~reset & (fill_q == FILL_MAX) & pat_eq;
    end

    assign out       = hit;
    assign count_sat = &match_count;

    // Pattern, history, fill level and match counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q       <= PATTERN;
            hist_q      <= {(PAT_W-1){1'b0}};
            fill_q      <= {FILL_W{1'b0}};
            match_count <= {CNT_W{1'b0}};
`ifdef SEQ_DET_MASK_EN
            mask_q      <= {PAT_W{1'b1}};
`endif
        end else begin
            if (pattern_ld) begin
                pat_q  <= pattern_in;
                hist_q <= {(PAT_W-1){1'b0}};
                fill_q <= {FILL_W{1'b0}};
`ifdef SEQ_DET_MASK_EN
                mask_q <= pattern_mask_in;
`endif
            end else if (in_valid) begin
                // Non-overlapping mode restarts from an empty history after a match.
                if (hit && !overlap_en) begin
                    hist_q <= {(PAT_W-1){1'b0}};
                    fill_q <= {FILL_W{1'b0}};
                end else begin
                    hist_q <= window[PAT_W-2:0];
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + FILL_W'(1);
                    end else begin
                        fill_q <= fill_q;
                    end
                end
            end else begin
                hist_q <= hist_q;
                fill_q <= fill_q;
            end

            if (count_clr) begin
                match_count <= hit ? CNT_W'(1) : {CNT_W{1'b0}};
            end else if (hit && !count_sat) begin
                match_count <= match_count + CNT_W'(1);
            end else begin
                match_count <= match_count;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Directed self-checking bench for seq_detector_mealy_param (default, CNT_W=2 and PAT_W=2 instances).
module tb_seq_detector_mealy_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       pattern_ld = 1'b0;
    logic [2:0] pattern_in = 3'b101;
    logic [1:0] pattern_in2 = 2'b11;
    logic [2:0] mask_in = 3'b111;
    logic [1:0] mask_in2 = 2'b11;
    logic       count_clr = 1'b0;

    logic       out, out_s, out2;
    logic [7:0] cnt;
    logic [1:0] cnt_s, cnt2;
    logic       sat, sat_s, sat2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detector_mealy_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap_en(overlap_en),
        .pattern_ld(pattern_ld), .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask_in(mask_in),
`endif
        .count_clr(count_clr), .out(out), .match_count(cnt), .count_sat(sat));

    seq_detector_mealy_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap_en(overlap_en),
        .pattern_ld(pattern_ld), .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask_in(mask_in),
`endif
        .count_clr(count_clr), .out(out_s), .match_count(cnt_s), .count_sat(sat_s));

    seq_detector_mealy_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) u_p2 (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap_en(overlap_en),
        .pattern_ld(pattern_ld), .pattern_in(pattern_in2),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask_in(mask_in2),
`endif
        .count_clr(count_clr), .out(out2), .match_count(cnt2), .count_sat(sat2));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle at negedge and check the Mealy output before the next posedge.
    task automatic cyc(input logic v, input logic b, input logic ld, input logic clr,
                       input logic exp_out, input string tag);
        @(negedge clk);
        in_valid = v; in = b; pattern_ld = ld; count_clr = clr;
        #1;
        check_eq(tag, {31'd0, out}, {31'd0, exp_out});
    endtask

    // Move just past the next posedge so registered results are visible.
    task automatic post;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in = 1'b1; pattern_ld = 1'b0; count_clr = 1'b0;
        #1;
        check_eq("rst_out", {31'd0, out}, 32'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in = 1'b0;
        #1;
        check_eq("rst_cnt", {24'd0, cnt}, 32'd0);
        check_eq("rst_sat", {30'd0, cnt_s, sat_s}, 32'd0);
    endtask

    initial begin
        // Overlapping 101 on 0,1,0,1,0,1
        overlap_en = 1'b1;
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ov_b1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ov_b2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ov_b3");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ov_b4");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ov_b5");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ov_b6");
        post();
        check_eq("ov_cnt", {24'd0, cnt}, 32'd2);

        // Non-overlapping 101 on 1,0,1,0,1
        overlap_en = 1'b0;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "no_b1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "no_b2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "no_b3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "no_b4");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "no_b5");
        post();
        check_eq("no_cnt", {24'd0, cnt}, 32'd1);

        // Valid gap between 1,0 and final 1
        overlap_en = 1'b1;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap_b1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap_b2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_i1");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_i2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_i3");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "gap_b3");
        post();
        check_eq("gap_cnt", {24'd0, cnt}, 32'd1);

        // Runtime load of 110 after 1,0; the load-cycle bit would have matched 101
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ld_b1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ld_b2");
        pattern_in = 3'b110;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "ld_cyc");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ld_n1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ld_n2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ld_n3");
        post();
        check_eq("ld_cnt", {24'd0, cnt}, 32'd1);
        pattern_in = 3'b101;

        // Reset restores 101; partial 1,0 before reset must not combine with 1 after
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rs_p1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rs_p2");
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rs_b1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rs_b2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "rs_b3");

        // Saturation on CNT_W=2: hits on bits 3,5,7,9,11; clear with the 5th
        do_reset();
        for (int i = 1; i <= 11; i++) begin
            cyc(1'b1, (i % 2 == 1) ? 1'b1 : 1'b0, 1'b0, (i == 11) ? 1'b1 : 1'b0,
                (i >= 3 && i % 2 == 1) ? 1'b1 : 1'b0, "sat_bit");
            if (i >= 3 && i % 2 == 1) begin
                post();
                case (i)
                    3:       check_eq("sat_h1", {29'd0, cnt_s, sat_s}, {29'd0, 2'd1, 1'b0});
                    5:       check_eq("sat_h2", {29'd0, cnt_s, sat_s}, {29'd0, 2'd2, 1'b0});
                    7:       check_eq("sat_h3", {29'd0, cnt_s, sat_s}, {29'd0, 2'd3, 1'b1});
                    9:       check_eq("sat_h4", {29'd0, cnt_s, sat_s}, {29'd0, 2'd3, 1'b1});
                    default: check_eq("sat_h5", {29'd0, cnt_s, sat_s}, {29'd0, 2'd1, 1'b0});
                endcase
            end
        end
        check_eq("wide_cnt", {24'd0, cnt}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_only");
        post();
        check_eq("clr_cnt", {29'd0, cnt_s, sat_s}, 32'd0);

        // PAT_W=2 pattern 11: overlapping then non-overlapping
        overlap_en = 1'b1;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p2o_b1"); check_eq("p2o_1", {31'd0, out2}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p2o_b2"); check_eq("p2o_2", {31'd0, out2}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p2o_b3"); check_eq("p2o_3", {31'd0, out2}, 32'd1);
        overlap_en = 1'b0;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p2n_b1"); check_eq("p2n_1", {31'd0, out2}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p2n_b2"); check_eq("p2n_2", {31'd0, out2}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p2n_b3"); check_eq("p2n_3", {31'd0, out2}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p2n_b4"); check_eq("p2n_4", {31'd0, out2}, 32'd1);
        post();
        check_eq("p2n_cnt", {30'd0, cnt2}, 32'd2);

`ifdef SEQ_DET_MASK_EN
        // Mask 101 makes the middle bit don't-care
        overlap_en = 1'b0;
        do_reset();
        pattern_in = 3'b101; mask_in = 3'b101;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mk_ld");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mk_a1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mk_a2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "mk_a3");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mk_b1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mk_b2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "mk_b3");
        mask_in = 3'b111;
`endif

        @(negedge clk);
        in_valid = 1'b0; pattern_ld = 1'b0; count_clr = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_mealy_param.md
Name: seq_detector_mealy_param

Overview:
Parametrised Mealy serial-pattern detector. It is the generalised successor to the fixed 3-bit "101" overlapping detector. Features:
- pattern width set by parameter; pattern value loadable at runtime
- overlapping or non-overlapping mode selected at runtime
- input qualifier (in_valid)
- saturating match counter

Sits on a serial bit stream in front of framing and sync-word logic.

Parameters:
PAT_W, 3, pattern length in bits; legal range 2..32.
PATTERN, 3'b101, reset value of the pattern register; MSB is the first bit received.
CNT_W, 8, width of match_count.

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-high reset
in  input  1  serial data bit
in_valid  input  1  in is sampled only when high
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
pattern_ld  input  1  load pattern_in into the pattern register
pattern_in  input  PAT_W  new pattern, MSB first
count_clr  input  1  clear match_count
out  output  1  Mealy match flag, combinational from in/in_valid and state
match_count  output  CNT_W  number of matches, saturating
count_sat  output  1  high while match_count equals all-ones

Behaviour:
- State registers:
  - pat_q[PAT_W-1:0]
  - hist_q[PAT_W-2:0]: last PAT_W-1 accepted bits, newest at LSB
  - fill_q: number of valid history bits, 0..PAT_W-1, width clog2(PAT_W)
  - match_count
- Reset (sync, highest priority):
  - pat_q=PATTERN, hist_q=0, fill_q=0, match_count=0
  - out=0 during and after reset until a match
- Match condition:
  - hit = in_valid & ~pattern_ld & ~reset & (fill_q==PAT_W-1) & ({hist_q,in}==pat_q)
  - out = hit, combinational in the same cycle as the last pattern bit; zero latency
- Accepted bit (in_valid=1, no pattern_ld):
  - hist_q <= {hist_q[PAT_W-3:0],in}
  - fill_q <= min(fill_q+1, PAT_W-1)
- On hit with overlap_en=1: history shifts normally and fill_q stays PAT_W-1, so a suffix of the current match can begin the next one.
- On hit with overlap_en=0: fill_q <= 0 and hist_q <= 0; the next match needs PAT_W fresh bits.
- in_valid=0: all state holds, out=0.
- pattern_ld=1:
  - pat_q <= pattern_in, hist_q <= 0, fill_q <= 0
  - the in bit in that cycle is discarded and out=0
  - match_count is unaffected
- Priority: reset > pattern_ld > in_valid.
- match_count:
  - increments by 1 on every hit, saturating at 2^CNT_W-1
  - count_sat = &match_count
  - count_clr alone sets it to 0
  - count_clr together with hit sets it to 1
- overlap_en may change at any cycle; it takes effect on the next hit evaluation.
- Edge cases:
  - PAT_W=2: hist_q is 1 bit.
  - fill_q saturating at PAT_W-1 means an arbitrarily long idle or valid stream never wraps the state.
- Reset mid-stream discards partial history; a partial pattern before reset never combines with bits after reset.

Optional Feature:
Macro: SEQ_DET_MASK_EN.
- Defined:
  - adds input port pattern_mask_in [PAT_W-1:0] and register mask_q (reset value all-ones)
  - mask_q loads with pattern_ld
  - comparison becomes (({hist_q,in} ^ pat_q) & mask_q)==0; a mask bit of 0 is don't-care
- Not defined: no port, no register; exact compare as above.

Test Plan:
- Default 101, overlap_en=1, reset then valid stream 0,1,0,1,0,1 -> out high on the 4th and 6th bits; match_count=2.
- Default 101, overlap_en=0, stream 1,0,1,0,1 -> out high on the 3rd bit only; match_count=1.
- Stream 1,0,(in_valid=0 for 3 cycles, in=0),1 -> out high on the final bit; the gap neither breaks nor adds bits.
- pattern_ld with pattern_in=3'b110 after bits 1,0, then stream 1,1,0 -> no out during the load cycle; out high on the 3rd bit after the load.
- CNT_W=2, 5 matches, count_clr asserted on the 5th -> count 1,2,3,3 with count_sat=1, then 1 on the 5th; count_clr alone -> 0.
- SEQ_DET_MASK_EN, pattern 101, mask 101 -> streams 1,1,1 and 1,0,1 both assert out on the 3rd bit.
